// File: rtl/priority_scanner_pkg.sv
// Shared types, defaults and parameter legality check for the priority scanner.
// Imported by both the top level and the combinational picker.
package priority_scanner_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam logic [7:0] DEFAULT_EMPTY_CODE = 8'hF0;

   // The index port must hold every bit position, and EMPTY_CODE must not alias one.
   function automatic bit params_legal(input int width, input int out_w, input int empty_code);
      return (width >= 2) && (width <= 128) &&
             ((longint'(1) << out_w) > longint'(width)) &&
             (empty_code >= width);
   endfunction

endpackage

// File: rtl/priority_scanner_pick.sv
// Combinational picker: the highest (dir=0) or lowest (dir=1) set bit of a mask.
// Also reports that bit as a one-hot clear vector and whether it is the only bit set.
module priority_pick #(
   parameter int WIDTH = 16,
   localparam int IDX_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] mask,
   input  logic             dir,
   output logic [IDX_W-1:0] index,
   output logic [WIDTH-1:0] onehot,
   output logic             single
);

   // Later hits overwrite earlier ones, so the walk order decides which end wins.
   always_comb begin
      index  = '0;
      onehot = '0;
      for (int i = 0; i < WIDTH; i++) begin
         int j;
         j = dir ? (WIDTH - 1 - i) : i;
         if (mask[j]) begin
            index     = IDX_W'(j);
            onehot    = '0;
            onehot[j] = 1'b1;
         end
      end
   end

   always_comb begin
      single = (mask != '0) && ((mask & (mask - 1'b1)) == '0);
   end

endmodule

// File: rtl/priority_scanner.sv
// Sequential priority scanner: accepts a word and emits the index of each set bit,
// one beat per handshake, MSB-first or LSB-first as chosen for that word.
module priority_scanner
   import priority_scanner_pkg::*;
#(
   parameter int                WIDTH      = 16,
   parameter int                OUT_W      = 8,
   parameter logic [OUT_W-1:0]  EMPTY_CODE = OUT_W'(DEFAULT_EMPTY_CODE),
   localparam int               CNT_W      = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             lsb_first,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_idx,
   output logic             out_last,
   output logic [CNT_W-1:0] out_count
);

   localparam int IDX_W = $clog2(WIDTH);

   if (!params_legal(WIDTH, OUT_W, int'(EMPTY_CODE))) begin : g_param_error
      $error("priority_scanner: illegal WIDTH/OUT_W/EMPTY_CODE combination");
   end

   state_t             state;
   logic [WIDTH-1:0]   mask;
   logic               dir;
   logic               empty_flag;
   logic [OUT_W-1:0]   beat_idx;
   logic               beat_last;
   logic [CNT_W-1:0]   beat_count;

   logic [WIDTH-1:0]   pick_mask;
   logic               pick_dir;
   logic [IDX_W-1:0]   pick_index;
   logic [WIDTH-1:0]   pick_onehot;
   logic               pick_single;

   logic               accept;
   logic               out_fire;

   // mask holds only the bits still to be reported after the current beat, so one
   // picker serves both the incoming word (in IDLE) and the next beat (in SCAN).
   assign pick_mask = (state == IDLE) ? in_data   : mask;
   assign pick_dir  = (state == IDLE) ? lsb_first : dir;

   priority_pick #(
      .WIDTH (WIDTH)
   ) u_pick (
      .mask   (pick_mask),
      .dir    (pick_dir),
      .index  (pick_index),
      .onehot (pick_onehot),
      .single (pick_single)
   );

   assign in_ready  = rst_n & ena & (state == IDLE);
   assign out_valid = ena & (state == SCAN);
   assign accept    = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   assign out_idx   = (out_valid && !empty_flag) ? beat_idx : EMPTY_CODE;
   assign out_last  = out_valid & beat_last;
   assign out_count = (out_valid && !empty_flag) ? beat_count : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mask       <= '0;
         dir        <= 1'b0;
         empty_flag <= 1'b0;
         beat_idx   <= EMPTY_CODE;
         beat_last  <= 1'b0;
         beat_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dir        <= lsb_first;
                  empty_flag <= (in_data == '0);
                  mask       <= in_data & ~pick_onehot;
                  beat_idx   <= OUT_W'(pick_index);
                  beat_last  <= pick_single | (in_data == '0);
                  beat_count <= CNT_W'(1);
                  state      <= SCAN;
               end
            end
            SCAN: begin
               if (out_fire) begin
                  if (beat_last) begin
                     mask       <= '0;
                     beat_count <= '0;
                     beat_last  <= 1'b0;
                     state      <= IDLE;
                  end else begin
                     mask       <= mask & ~pick_onehot;
                     beat_idx   <= OUT_W'(pick_index);
                     beat_last  <= pick_single;
                     beat_count <= CNT_W'(beat_count + 1'b1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_priority_scanner.sv
// Directed self-checking bench for priority_scanner with hand-computed beats.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_priority_scanner;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        ena;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_data;
   logic        lsb_first;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_idx;
   logic        out_last;
   logic [4:0]  out_count;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   priority_scanner dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .lsb_first (lsb_first),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .out_count (out_count)
   );

   task automatic apply_stimulus(input logic v, input logic [15:0] d, input logic lf,
                                 input logic ordy, input logic en);
      @(negedge clk);
      in_valid  = v;
      in_data   = d;
      lsb_first = lf;
      out_ready = ordy;
      ena       = en;
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_beat(input string tag, input logic [7:0] idx,
                              input logic last, input logic [4:0] cnt);
      check_output({tag, ".valid"}, 32'(out_valid), 32'd1);
      check_output({tag, ".ready"}, 32'(in_ready), 32'd0);
      check_output({tag, ".idx"},   32'(out_idx), 32'(idx));
      check_output({tag, ".last"},  32'(out_last), 32'(last));
      check_output({tag, ".count"}, 32'(out_count), 32'(cnt));
   endtask

   task automatic expect_quiet(input string tag, input logic rdy);
      check_output({tag, ".valid"}, 32'(out_valid), 32'd0);
      check_output({tag, ".ready"}, 32'(in_ready), 32'(rdy));
      check_output({tag, ".idx"},   32'(out_idx), 32'hF0);
      check_output({tag, ".last"},  32'(out_last), 32'd0);
      check_output({tag, ".count"}, 32'(out_count), 32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      ena       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      lsb_first = 1'b0;
      out_ready = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      expect_quiet("reset", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      expect_quiet("post_reset", 1'b1);

      // Empty word: one EMPTY beat, ready again two cycles after accept
      apply_stimulus(1'b1, 16'h0000, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("empty.b1", 8'hF0, 1'b1, 5'd0);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_quiet("empty.idle", 1'b1);

      // MSB-first 8001
      apply_stimulus(1'b1, 16'h8001, 1'b0, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b1);
      expect_beat("msb.b1", 8'd15, 1'b0, 5'd1);
      apply_stimulus(1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
      expect_beat("msb.b2", 8'd0, 1'b1, 5'd2);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_quiet("msb.idle", 1'b1);

      // LSB-first 8001
      apply_stimulus(1'b1, 16'h8001, 1'b1, 1'b1, 1'b1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("lsb.b1", 8'd0, 1'b0, 5'd1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("lsb.b2", 8'd15, 1'b1, 5'd2);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_quiet("lsb.idle", 1'b1);

      // Full word: 16 back-to-back beats, then one bubble
      apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
         expect_beat($sformatf("full.b%0d", i), 8'(16 - i), (i == 16), 5'(i));
      end

      // Backpressure then stall on 0A00; accepted in the bubble after the full word
      apply_stimulus(1'b1, 16'h0A00, 1'b0, 1'b0, 1'b1);
      check_output("bp.accept_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
         expect_beat($sformatf("bp.hold%0d", i), 8'd11, 1'b0, 5'd1);
      end
      for (int i = 0; i < 2; i++) begin
         apply_stimulus(1'b1, 16'h0001, 1'b1, 1'b1, 1'b0);
         expect_quiet($sformatf("bp.stall%0d", i), 1'b0);
      end
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("bp.b1", 8'd11, 1'b0, 5'd1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("bp.b2", 8'd9, 1'b1, 5'd2);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_quiet("bp.idle", 1'b1);

      // Reset mid-scan after beat 4, then a fresh single-bit word
      apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
         expect_beat($sformatf("rst.b%0d", i), 8'(16 - i), 1'b0, 5'(i));
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      expect_quiet("rst.forced", 1'b0);
      @(negedge clk);
      rst_n     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 16'h0010;
      lsb_first = 1'b0;
      #1;
      check_output("rst.release_ready", 32'(in_ready), 32'd1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_beat("rst.new", 8'd4, 1'b1, 5'd1);
      apply_stimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
      expect_quiet("rst.idle", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
